// File: rtl/apb_xbar.sv
// rtl/apb_xbar.sv - single-initiator, TGT_N-target APB interconnect with base/mask decode and watchdog
module apb_xbar #(
    parameter int                    TGT_N       = 3,
    parameter int                    TGT_ADDR_W  = 31,
    parameter logic [32*TGT_N-1:0]   TGT_BASE    = {32'h0C00_0000, 32'h1000_0000, 32'h8000_0000},
    parameter logic [32*TGT_N-1:0]   TGT_MASK    = {32'h03FF_FFFF, 32'h0000_0FFF, 32'h7FFF_FFFF},
    parameter int                    TIMEOUT_CYC = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_psel,
    input  logic                    i_penable,
    input  logic [31:0]             i_paddr,
    input  logic                    i_pwrite,
    input  logic [31:0]             i_pwdata,
    input  logic [3:0]              i_pwstrb,
    output logic                    i_pready,
    output logic [31:0]             i_prdata,
    output logic                    i_pslverr,
    output logic [TGT_N-1:0]        t_psel,
    output logic                    t_penable,
    output logic [TGT_ADDR_W-1:0]   t_paddr,
    output logic                    t_pwrite,
    output logic [31:0]             t_pwdata,
    output logic [3:0]              t_pwstrb,
    input  logic [TGT_N-1:0]        t_pready,
    input  logic [32*TGT_N-1:0]     t_prdata,
    input  logic [TGT_N-1:0]        t_pslverr,
    output logic                    err_decode,
    output logic                    err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        T_SETUP  = 2'd1,
        T_ACCESS = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [TGT_N-1:0]        sel_q, sel_d;
    logic [TGT_ADDR_W-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    slverr_q, slverr_d;
    logic                    dec_err_q, dec_err_d;
    logic                    to_err_q, to_err_d;

    logic [TGT_N-1:0]        hit_sel;
    logic                    hit;
    logic [31:0]             hit_off;
    logic [31:0]             sel_rdata;
    logic                    sel_ready;
    logic                    sel_err;

    // Lowest-index target wins when address windows overlap.
    always_comb begin
        hit_sel = '0;
        hit     = 1'b0;
        hit_off = '0;
        for (int k = 0; k < TGT_N; k++) begin
            if (!hit && ((i_paddr & ~TGT_MASK[32*k +: 32]) == TGT_BASE[32*k +: 32])) begin
                hit_sel[k] = 1'b1;
                hit        = 1'b1;
                hit_off    = i_paddr & TGT_MASK[32*k +: 32];
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < TGT_N; k++) begin
            if (sel_q[k]) begin
                sel_rdata = sel_rdata | t_prdata[32*k +: 32];
            end
        end
        sel_ready = |(t_pready & sel_q);
        sel_err   = |(t_pslverr & sel_q);
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        dec_err_d = dec_err_q;
        to_err_d  = to_err_q;
        unique case (state_q)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    sel_d     = hit_sel;
                    addr_d    = TGT_ADDR_W'(hit_off);
                    write_d   = i_pwrite;
                    wdata_d   = i_pwdata;
                    wstrb_d   = i_pwstrb;
                    rdata_d   = '0;
                    to_err_d  = 1'b0;
                    if (hit) begin
                        slverr_d  = 1'b0;
                        dec_err_d = 1'b0;
                        state_d   = T_SETUP;
                    end else begin
                        slverr_d  = 1'b1;
                        dec_err_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            T_SETUP: begin
                cnt_d   = '0;
                state_d = T_ACCESS;
            end
            T_ACCESS: begin
                if (sel_ready) begin
                    rdata_d  = sel_rdata;
                    slverr_d = sel_err;
                    state_d  = RESP;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d  = '0;
                    slverr_d = 1'b1;
                    to_err_d = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rdata_d   = '0;
                slverr_d  = 1'b0;
                dec_err_d = 1'b0;
                to_err_d  = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            dec_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            dec_err_q <= dec_err_d;
            to_err_q  <= to_err_d;
        end
    end

    // Outputs are gated by state so the target bus reads zero outside a transfer.
    logic busy;
    assign busy        = (state_q == T_SETUP) || (state_q == T_ACCESS);
    assign t_psel      = busy ? sel_q : '0;
    assign t_penable   = (state_q == T_ACCESS);
    assign t_paddr     = busy ? addr_q : '0;
    assign t_pwrite    = busy & write_q;
    assign t_pwdata    = busy ? wdata_q : '0;
    assign t_pwstrb    = busy ? wstrb_q : '0;
    assign i_pready    = (state_q == RESP);
    assign i_prdata    = i_pready ? rdata_q : '0;
    assign i_pslverr   = i_pready & slverr_q;
    assign err_decode  = i_pready & dec_err_q;
    assign err_timeout = i_pready & to_err_q;

endmodule
